// File: rtl/io_button_if.sv
// IO bus bundle for the dma_io daisy chain: write port, read request and chained read data.
interface io_button_if;
  logic        dma_io_we;
  logic [15:2] dma_io_wadr;
  logic [31:0] dma_io_wdata;
  logic [15:2] dma_io_radr;
  logic        dma_io_radr_en;
  logic [31:0] dma_io_rdata_in;
  logic [31:0] dma_io_rdata;

  modport master (
    output dma_io_we, dma_io_wadr, dma_io_wdata, dma_io_radr, dma_io_radr_en, dma_io_rdata_in,
    input  dma_io_rdata
  );

  modport slave (
    input  dma_io_we, dma_io_wadr, dma_io_wdata, dma_io_radr, dma_io_radr_en, dma_io_rdata_in,
    output dma_io_rdata
  );
endinterface

// File: rtl/io_button.sv
// Debounced push-button peripheral with sticky press capture and level interrupt.
// Define BTN_RELEASE_CAPTURE_EN to add a release-capture register at word address 14'h3F84.
module io_button #(
  parameter int unsigned NBTN           = 4,
  parameter logic [15:0] DB_CYCLES      = 16'd50000,
  parameter bit          BTN_ACTIVE_LOW = 1'b1,
  parameter logic [13:0] ADR_STAT       = 14'h3F81,
  parameter logic [13:0] ADR_EDGE       = 14'h3F82,
  parameter logic [13:0] ADR_IEN        = 14'h3F83
) (
  input  logic            clk,
  input  logic            rst_n,
  io_button_if.slave      bus,
  input  logic [NBTN-1:0] btn_in,
  output logic            btn_irq
);

  logic [NBTN-1:0] btn_raw, sync1_q, sync_q, stable_q, stable_d, rise;
  logic [15:0]     cnt_q [NBTN];
  logic [15:0]     cnt_d [NBTN];
  logic [NBTN-1:0] capture_q, capture_d, edge_clr, ien_q, irq_src;
  logic            irq_q, hit_q, rd_hit;
  logic [31:0]     rdata_q, rd_sel;
  logic            wr_edge, wr_ien;
  logic            unused_wdata;

  assign unused_wdata = ^bus.dma_io_wdata[31:NBTN];

  // Normalise so that 1 always means pressed; reset value 0 then reads as released.
  assign btn_raw = BTN_ACTIVE_LOW ? ~btn_in : btn_in;

  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < NBTN; i++) begin
      cnt_d[i] = '0;
      if (sync_q[i] != stable_q[i]) begin
        if (cnt_q[i] == DB_CYCLES - 16'd1) begin
          stable_d[i] = sync_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 16'd1;
        end
      end
    end
  end

  assign rise     = stable_d & ~stable_q;
  assign wr_edge  = bus.dma_io_we && (bus.dma_io_wadr == ADR_EDGE);
  assign wr_ien   = bus.dma_io_we && (bus.dma_io_wadr == ADR_IEN);
  assign edge_clr = wr_edge ? bus.dma_io_wdata[NBTN-1:0] : '0;
  // A new edge in the same cycle as a W1C clear keeps the bit set.
  assign capture_d = (capture_q & ~edge_clr) | rise;

`ifdef BTN_RELEASE_CAPTURE_EN
  localparam logic [13:0] ADR_REL = 14'h3F84;

  logic [NBTN-1:0] rcapture_q, rcapture_d, rel_clr, fall;
  logic            wr_rel;

  assign fall       = ~stable_d & stable_q;
  assign wr_rel     = bus.dma_io_we && (bus.dma_io_wadr == ADR_REL);
  assign rel_clr    = wr_rel ? bus.dma_io_wdata[NBTN-1:0] : '0;
  assign rcapture_d = (rcapture_q & ~rel_clr) | fall;
  assign irq_src    = (capture_q | rcapture_q) & ien_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rcapture_q <= '0;
    end else begin
      rcapture_q <= rcapture_d;
    end
  end
`else
  assign irq_src = capture_q & ien_q;
`endif

  always_comb begin
    rd_sel = '0;
    rd_hit = 1'b0;
    if (bus.dma_io_radr_en) begin
      case (bus.dma_io_radr)
        ADR_STAT: begin
          rd_hit            = 1'b1;
          rd_sel[NBTN-1:0]  = stable_q;
        end
        ADR_EDGE: begin
          rd_hit            = 1'b1;
          rd_sel[NBTN-1:0]  = capture_q;
        end
        ADR_IEN: begin
          rd_hit            = 1'b1;
          rd_sel[NBTN-1:0]  = ien_q;
        end
`ifdef BTN_RELEASE_CAPTURE_EN
        ADR_REL: begin
          rd_hit            = 1'b1;
          rd_sel[NBTN-1:0]  = rcapture_q;
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= '0;
      sync_q    <= '0;
      stable_q  <= '0;
      for (int i = 0; i < NBTN; i++) cnt_q[i] <= '0;
      capture_q <= '0;
      ien_q     <= '0;
      irq_q     <= 1'b0;
      hit_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      sync1_q   <= btn_raw;
      sync_q    <= sync1_q;
      stable_q  <= stable_d;
      for (int i = 0; i < NBTN; i++) cnt_q[i] <= cnt_d[i];
      capture_q <= capture_d;
      if (wr_ien) ien_q <= bus.dma_io_wdata[NBTN-1:0];
      irq_q     <= |irq_src;
      hit_q     <= rd_hit;
      if (rd_hit) rdata_q <= rd_sel;
    end
  end

  assign bus.dma_io_rdata = hit_q ? rdata_q : bus.dma_io_rdata_in;
  assign btn_irq          = irq_q;

endmodule
